// File: rtl/asic_io_chan.sv
// asic_io_chan: NUM_CH byte-wide peripheral output channels on the Z80 I/O bus.
// Each channel has a TX FIFO, a strobe/ack handshake FSM, sticky error flags
// and a status/control register.
//
// Ports:
//   clk_sys    system clock
//   reset      synchronous, active-high reset
//   io_enable  0 blocks CPU writes and status read-clears (channels keep draining)
//   cpu_addr   I/O address, only [7:0] decoded
//   cpu_data   write data
//   cpu_wr     single-cycle write strobe
//   cpu_rd     single-cycle read strobe
//   io_dout    combinational read data (8'hFF outside the channel window)
//   ch_data    per-channel output byte, channel i at [8i+7:8i]
//   ch_strobe  per-channel data-valid strobe
//   ch_ack     per-channel acknowledge (level, synchronous to clk_sys)
//   irq        registered OR of enabled channel error flags
//
// Address map, channel i: data port BASE_ADDR+2i, status/control BASE_ADDR+2i+1.
// Status read: {en, irq_en, tmo, ovf, busy, full, empty, 1'b0}.
// Control write: bit0 en, bit1 flush (self-clearing), bit2 irq_en.
//
// Optional feature: define ASIC_IO_TIMEOUT_EN to abandon a byte after
// TIMEOUT_CYCLES cycles in WAIT_ACK and set the sticky tmo flag.

module asic_io_chan #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned STROBE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  BASE_ADDR      = 8'h74
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                io_enable,
  input  logic [15:0]         cpu_addr,
  input  logic [7:0]          cpu_data,
  input  logic                cpu_wr,
  input  logic                cpu_rd,
  output logic [7:0]          io_dout,
  output logic [8*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]   ch_strobe,
  input  logic [NUM_CH-1:0]   ch_ack,
  output logic                irq
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StStrobe, StWaitAck} state_e;

  state_e                   r_state [NUM_CH];
  logic [7:0]               r_mem   [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]            r_rd    [NUM_CH];
  logic [PW-1:0]            r_wr    [NUM_CH];
  logic [CW-1:0]            r_cnt   [NUM_CH];
  logic [SW-1:0]            r_scnt  [NUM_CH];
  logic [NUM_CH-1:0]        r_en, r_irq_en, r_ovf, r_strobe;
  logic [NUM_CH-1:0][7:0]   r_data;
  logic                     r_irq;

  logic [7:0]               w_addr, w_off;
  logic                     w_hit, w_is_ctl;
  logic [NUM_CH-1:0]        w_sel, w_full, w_empty, w_data_wr, w_ctl_wr, w_stat_rd;
  logic [NUM_CH-1:0]        w_flush, w_pop, w_push, w_drop, w_tmo, w_tmo_set;
  logic                     w_unused;

`ifdef ASIC_IO_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0]            r_tcnt [NUM_CH];
  logic [NUM_CH-1:0]        r_tmo;
  assign w_tmo = r_tmo;
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_tmo_set[i] = (r_state[i] == StWaitAck) && !ch_ack[i] && !w_flush[i] &&
                     (r_tcnt[i] == TW'(TIMEOUT_CYCLES - 1));
    end
  end
`else
  assign w_tmo     = '0;
  assign w_tmo_set = '0;
`endif

  // Address decode: the compare on w_addr rules out wrap-around in w_off.
  assign w_addr   = cpu_addr[7:0];
  assign w_off    = w_addr - BASE_ADDR;
  assign w_hit    = (w_addr >= BASE_ADDR) && (w_off < 8'(2 * NUM_CH));
  assign w_is_ctl = w_off[0];
  assign w_unused = ^{cpu_addr[15:8], w_tmo_set};

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i]     = w_hit && (w_off[7:1] == 7'(i));
      w_full[i]    = (r_cnt[i] == CW'(FIFO_DEPTH));
      w_empty[i]   = (r_cnt[i] == '0);
      w_data_wr[i] = io_enable && cpu_wr && w_sel[i] && !w_is_ctl;
      w_ctl_wr[i]  = io_enable && cpu_wr && w_sel[i] && w_is_ctl;
      w_stat_rd[i] = io_enable && cpu_rd && w_sel[i] && w_is_ctl;
      w_flush[i]   = w_ctl_wr[i] && cpu_data[1];
      w_pop[i]     = (r_state[i] == StIdle) && r_en[i] && !w_empty[i] && !w_flush[i];
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      w_push[i]    = w_data_wr[i] && (!w_full[i] || w_pop[i]);
      w_drop[i]    = w_data_wr[i] && w_full[i] && !w_pop[i];
    end
  end

  always_comb begin
    io_dout = 8'hFF;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel[i]) begin
        io_dout = w_is_ctl ? {r_en[i], r_irq_en[i], w_tmo[i], r_ovf[i],
                              (r_state[i] != StIdle), w_full[i], w_empty[i], 1'b0}
                           : 8'(r_cnt[i]);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i]) r_mem[i][r_wr[i]] <= cpu_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= StIdle;
        r_rd[i]    <= '0;
        r_wr[i]    <= '0;
        r_cnt[i]   <= '0;
        r_scnt[i]  <= '0;
`ifdef ASIC_IO_TIMEOUT_EN
        r_tcnt[i]  <= '0;
`endif
      end
`ifdef ASIC_IO_TIMEOUT_EN
      r_tmo    <= '0;
`endif
      r_en     <= '0;
      r_irq_en <= '0;
      r_ovf    <= '0;
      r_strobe <= '0;
      r_data   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_irq <= |(r_irq_en & (r_ovf | w_tmo));
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ctl_wr[i]) begin
          r_en[i]     <= cpu_data[0];
          r_irq_en[i] <= cpu_data[2];
        end
        // Set beats read-clear when both happen in one cycle.
        r_ovf[i] <= w_drop[i] || (r_ovf[i] && !w_stat_rd[i]);
`ifdef ASIC_IO_TIMEOUT_EN
        r_tmo[i] <= w_tmo_set[i] || (r_tmo[i] && !w_stat_rd[i]);
`endif

        if (w_flush[i]) begin
          r_rd[i]  <= '0;
          r_wr[i]  <= '0;
          r_cnt[i] <= '0;
        end else begin
          if (w_push[i]) r_wr[i] <= r_wr[i] + 1'b1;
          if (w_pop[i])  r_rd[i] <= r_rd[i] + 1'b1;
          if (w_push[i] && !w_pop[i])      r_cnt[i] <= r_cnt[i] + 1'b1;
          else if (w_pop[i] && !w_push[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
        end

        if (w_flush[i]) begin
          r_state[i]  <= StIdle;
          r_strobe[i] <= 1'b0;
        end else begin
          case (r_state[i])
            StIdle: begin
              if (w_pop[i]) begin
                r_data[i]   <= r_mem[i][r_rd[i]];
                r_strobe[i] <= 1'b1;
                r_scnt[i]   <= SW'(STROBE_CYCLES - 1);
                r_state[i]  <= StStrobe;
              end
            end
            StStrobe: begin
              if (r_scnt[i] == '0) begin
                r_strobe[i] <= 1'b0;
                r_state[i]  <= StWaitAck;
`ifdef ASIC_IO_TIMEOUT_EN
                r_tcnt[i]   <= '0;
`endif
              end else begin
                r_scnt[i] <= r_scnt[i] - 1'b1;
              end
            end
            StWaitAck: begin
              if (ch_ack[i]) begin
                r_state[i] <= StIdle;
`ifdef ASIC_IO_TIMEOUT_EN
              end else if (w_tmo_set[i]) begin
                r_state[i] <= StIdle;
              end else begin
                r_tcnt[i] <= r_tcnt[i] + 1'b1;
`endif
              end
            end
            default: r_state[i] <= StIdle;
          endcase
        end
      end
    end
  end

  assign ch_data   = r_data;
  assign ch_strobe = r_strobe;
  assign irq       = r_irq;

endmodule

// File: tb/tb_asic_io_chan.sv
module tb_asic_io_chan;
  localparam int NCH   = 4;
  localparam int DEPTH = 8;
  localparam int STB   = 4;
  localparam int TMO   = 16;
  localparam logic [7:0] BASE = 8'h74;

  logic             clk_sys = 1'b0;
  logic             reset = 1'b1;
  logic             io_enable = 1'b1;
  logic [15:0]      cpu_addr = '0;
  logic [7:0]       cpu_data = '0;
  logic             cpu_wr = 1'b0;
  logic             cpu_rd = 1'b0;
  logic [7:0]       io_dout;
  logic [8*NCH-1:0] ch_data;
  logic [NCH-1:0]   ch_strobe;
  logic [NCH-1:0]   ch_ack = '0;
  logic             irq;

  int n_chk = 0;
  int n_err = 0;

  // Reference model for the random phase: per-channel queue of expected bytes.
  logic [7:0] exp_q [4][$];
  int         pushed [4];
  int         started [4];
  int         width [4];
  int         ack_wait [4];
  bit         ack_pend [4];
  bit         prev_s [4];
  int         rc;
  logic [7:0] rb;
  logic [7:0] d;
  bit         quiet;

  always #5 clk_sys = ~clk_sys;

  asic_io_chan #(
    .NUM_CH(NCH), .FIFO_DEPTH(DEPTH), .STROBE_CYCLES(STB),
    .TIMEOUT_CYCLES(TMO), .BASE_ADDR(BASE)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .io_enable(io_enable), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .io_dout(io_dout),
    .ch_data(ch_data), .ch_strobe(ch_strobe), .ch_ack(ch_ack), .irq(irq)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    cpu_addr = {8'h00, a};
    cpu_data = v;
    cpu_wr   = 1'b1;
    tick();
    cpu_wr   = 1'b0;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    cpu_addr = {8'h00, a};
    cpu_rd   = 1'b1;
    #1;
    check(tag, io_dout, exp);
    tick();
    cpu_rd   = 1'b0;
  endtask

  task automatic peek_chk(input logic [7:0] a, input logic [7:0] exp, input string tag);
    cpu_addr = {8'h00, a};
    #1;
    check(tag, io_dout, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state and address window edges.
    check("rst_strobe", ch_strobe, '0);
    check("rst_data", ch_data, '0);
    check("rst_irq", irq, 1'b0);
    rd_chk(8'h75, 8'h02, "rst_stat0");
    rd_chk(8'h7B, 8'h02, "rst_stat3");
    rd_chk(8'h7C, 8'hFF, "oor_hi");
    rd_chk(8'h73, 8'hFF, "oor_lo");

    // Single byte on ch0: 2-cycle latency, STB-cycle strobe, ack returns to idle.
    wr(8'h75, 8'h01);
    wr(8'h74, 8'hA5);
    check("lat_pre", ch_strobe[0], 1'b0);
    tick();
    for (int k = 0; k < STB; k++) begin
      check("stb_hi", ch_strobe[0], 1'b1);
      check("stb_data", ch_data[7:0], 8'hA5);
      tick();
    end
    check("stb_lo", ch_strobe[0], 1'b0);
    rd_chk(8'h75, 8'h8A, "busy_wait");
    ch_ack[0] = 1'b1;
    tick();
    ch_ack[0] = 1'b0;
    rd_chk(8'h75, 8'h82, "ack_idle");
    check("data_hold", ch_data[7:0], 8'hA5);

    // Overflow on disabled ch1, read-clear of ovf.
    for (int k = 0; k < 9; k++) wr(8'h76, 8'(16 + k));
    rd_chk(8'h76, 8'd8, "cnt_full");
    rd_chk(8'h77, 8'h14, "ovf_full");
    rd_chk(8'h77, 8'h04, "ovf_clr");

    // irq follows an enabled flag one cycle late, and drops after read-clear.
    wr(8'h77, 8'h04);
    wr(8'h76, 8'hEE);
    tick();
    check("irq_set", irq, 1'b1);
    rd_chk(8'h77, 8'h54, "irq_stat");
    tick();
    check("irq_clr", irq, 1'b0);

    // io_enable=0 ignores writes and read-clears.
    io_enable = 1'b0;
    wr(8'h76, 8'h77);
    wr(8'h77, 8'h00);
    rd_chk(8'h77, 8'h44, "ioen_wr");
    io_enable = 1'b1;
    rd_chk(8'h77, 8'h44, "ioen_ctl");
    wr(8'h76, 8'h88);
    io_enable = 1'b0;
    rd_chk(8'h77, 8'h54, "ioen_rd1");
    rd_chk(8'h77, 8'h54, "ioen_rd2");
    io_enable = 1'b1;
    rd_chk(8'h77, 8'h54, "ioen_rd3");
    rd_chk(8'h77, 8'h44, "ioen_rd4");
    wr(8'h77, 8'h02);
    rd_chk(8'h76, 8'd0, "ch1_flush");
    tick();
    check("irq_idle", irq, 1'b0);

    // Flush during STROBE.
    wr(8'h75, 8'h00);
    for (int k = 0; k < 4; k++) wr(8'h74, 8'(8'hB0 + k));
    wr(8'h75, 8'h01);
    tick();
    check("fl_strobe", ch_strobe[0], 1'b1);
    check("fl_data", ch_data[7:0], 8'hB0);
    rd_chk(8'h74, 8'd3, "fl_cnt3");
    wr(8'h75, 8'h03);
    check("fl_stb_lo", ch_strobe[0], 1'b0);
    rd_chk(8'h74, 8'd0, "fl_cnt0");
    rd_chk(8'h75, 8'h82, "fl_idle");
    check("fl_stay_lo", ch_strobe[0], 1'b0);
    check("fl_hold", ch_data[7:0], 8'hB0);

`ifdef ASIC_IO_TIMEOUT_EN
    // Timeout: never ack, byte abandoned after TMO cycles, next byte strobes.
    wr(8'h74, 8'hC1);
    wr(8'h74, 8'hC2);
    check("to_stb", ch_strobe[0], 1'b1);
    for (int k = 0; k < 10 && ch_strobe[0]; k++) tick();
    check("to_stb_lo", ch_strobe[0], 1'b0);
    repeat (TMO - 1) tick();
    peek_chk(8'h75, 8'h88, "to_wait");
    tick();
    peek_chk(8'h75, 8'hA0, "to_set");
    tick();
    check("to_next_stb", ch_strobe[0], 1'b1);
    check("to_next_data", ch_data[7:0], 8'hC2);
    peek_chk(8'h75, 8'hAA, "to_next_stat");
    for (int k = 0; k < 10 && ch_strobe[0]; k++) tick();
    ch_ack[0] = 1'b1;
    tick();
    ch_ack[0] = 1'b0;
    rd_chk(8'h75, 8'hA2, "to_rd");
    rd_chk(8'h75, 8'h82, "to_clr");
`endif

    // Random traffic on ch2/ch3 with random ack delays, checked against queues.
    wr(8'h79, 8'h01);
    wr(8'h7B, 8'h01);
    quiet = 1'b0;
    for (int cyc = 0; cyc < 1200 && !quiet; cyc++) begin
      for (int c = 2; c < 4; c++) begin
        if (ch_strobe[c] && !prev_s[c]) begin
          check("rnd_expect", exp_q[c].size() != 0, 1'b1);
          if (exp_q[c].size() != 0) check("rnd_byte", ch_data[8*c +: 8], exp_q[c].pop_front());
          started[c]++;
          width[c] = 1;
        end else if (ch_strobe[c]) begin
          width[c]++;
        end else if (prev_s[c]) begin
          check("rnd_width", width[c], STB);
          ack_pend[c] = 1'b1;
          ack_wait[c] = $urandom_range(0, 5);
        end
        prev_s[c] = ch_strobe[c];
      end
      quiet = (cyc >= 800) && exp_q[2].size() == 0 && exp_q[3].size() == 0 &&
              !ack_pend[2] && !ack_pend[3] && ch_strobe[3:2] == 2'b00;
      if (!quiet) begin
        for (int c = 2; c < 4; c++) begin
          ch_ack[c] = 1'b0;
          if (ack_pend[c]) begin
            if (ack_wait[c] == 0) begin
              ch_ack[c]   = 1'b1;
              ack_pend[c] = 1'b0;
            end else begin
              ack_wait[c]--;
            end
          end
        end
        cpu_wr = 1'b0;
        if (cyc < 800 && $urandom_range(0, 2) != 0) begin
          rc = 2 + $urandom_range(0, 1);
          if (pushed[rc] - started[rc] < DEPTH - 2) begin
            rb       = 8'($urandom);
            cpu_addr = 16'(BASE + 2 * rc);
            cpu_data = rb;
            cpu_wr   = 1'b1;
            exp_q[rc].push_back(rb);
            pushed[rc]++;
          end
        end
        tick();
      end
    end
    cpu_wr = 1'b0;
    ch_ack = '0;
    check("rnd_drain", quiet, 1'b1);
    check("rnd_count2", started[2], pushed[2]);
    rd_chk(8'h79, 8'h82, "rnd_stat2");
    rd_chk(8'h7B, 8'h82, "rnd_stat3");

    // Reset mid-transfer drops strobe on the next cycle.
    wr(8'h74, 8'h5A);
    tick();
    check("rm_stb", ch_strobe[0], 1'b1);
    reset = 1'b1;
    tick();
    check("rm_stb_lo", ch_strobe[0], 1'b0);
    check("rm_data", ch_data, '0);
    reset = 1'b0;
    tick();
    rd_chk(8'h75, 8'h02, "rm_stat");
    check("rm_irq", irq, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/asic_io_chan.md
Name: asic_io_chan

Overview:
- Parametrised successor to the Plus/GX4000 ASIC peripheral-port logic: NUM_CH identical byte-wide output channels (printer, RS232, Playcity, expansion).
- Each channel has a TX FIFO, a strobe/ack handshake FSM, sticky error flags and a status/control register.
- Sits on the Z80 I/O bus beside the ASIC register file; io_dout is muxed into the CPU read path.

Parameters:
- NUM_CH, 4: number of channels (1..8).
- FIFO_DEPTH, 8: entries per channel FIFO; power of 2, 2..128.
- STROBE_CYCLES, 4: clk_sys cycles ch_strobe stays high per byte (>=1).
- TIMEOUT_CYCLES, 65535: maximum WAIT_ACK cycles (used only with the optional feature).
- BASE_ADDR, 8'h74: low-byte I/O address of channel 0 data port.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high
- io_enable  in  1  gx4000_mode | plus_mode; 0 blocks CPU writes and read-clears
- cpu_addr  in  16  I/O address; only [7:0] decoded
- cpu_data  in  8  write data
- cpu_wr  in  1  single-cycle write strobe
- cpu_rd  in  1  single-cycle read strobe
- io_dout  out  8  combinational read data
- ch_data  out  8*NUM_CH  per-channel output byte, channel i at [8i+7:8i]
- ch_strobe  out  NUM_CH  per-channel data-valid strobe
- ch_ack  in  NUM_CH  per-channel acknowledge, level, synchronous to clk_sys
- irq  out  1  OR of enabled channel error flags

Behaviour:
- Address map, channel i:
  - Data port at BASE_ADDR+2i.
  - Status/control port at BASE_ADDR+2i+1.
  - Addresses outside BASE_ADDR..BASE_ADDR+2*NUM_CH-1 read 8'hFF.
- Data port write: pushes cpu_data into FIFO i.
  - If full, the byte is dropped and ovf_i (sticky) is set.
- Data port read: returns FIFO count, zero-extended (0..FIFO_DEPTH).
- Control write (status port):
  - bit0 en_i.
  - bit1 flush, self-clearing: empties FIFO; if the FSM is in STROBE or WAIT_ACK it goes to IDLE and ch_strobe is low the next cycle.
  - bit2 irq_en_i.
- Status read: {en, irq_en, tmo, ovf, busy, full, empty, 1'b0}.
  - busy = FSM not IDLE.
  - A cpu_rd on the status port clears tmo_i and ovf_i at the end of that cycle; the read still returns the pre-clear values.
  - A flag set in the same cycle as the clear wins (stays set).
- Channel FSM:
  - IDLE: if en_i and FIFO not empty, pop the head into ch_data_i, assert ch_strobe_i, go to STROBE. Latency from push into an empty enabled channel to ch_strobe high: 2 cycles.
  - STROBE: hold ch_strobe for STROBE_CYCLES cycles; ch_ack is ignored. Then drop strobe and go to WAIT_ACK.
  - WAIT_ACK: ch_ack_i high -> IDLE. Back-to-back bytes are possible, with a 1-cycle IDLE gap.
- Push and pop in the same cycle: count unchanged, no overflow even if full.
- Clearing en_i mid-transfer: the current byte completes; no further pops.
- ch_data_i holds the last sent byte until the next pop.
- irq = OR_i(irq_en_i & (ovf_i | tmo_i)), registered, so 1 cycle after the flag sets.
- io_enable=0: writes and read-clears are ignored; FSMs and FIFOs keep draining.
- Reset values:
  - ch_data 0, ch_strobe 0, irq 0.
  - FIFOs empty; all en/irq_en/ovf/tmo 0; FSMs IDLE.
  - Reset mid-transfer drops strobe on the next cycle.

Optional Feature:
- Macro ASIC_IO_TIMEOUT_EN.
- Defined:
  - A per-channel counter runs in WAIT_ACK.
  - After TIMEOUT_CYCLES cycles without ack, tmo_i is set and the FSM returns to IDLE; the byte is discarded.
- Undefined:
  - WAIT_ACK waits indefinitely.
  - tmo bits read 0, no counter logic is generated, and irq depends on ovf only.

Test Plan:
- Reset, then read 0x75 -> 8'h02 (empty). Read 0x7C -> 8'hFF.
- Write 0x75=8'h01, then 0x74=8'hA5 -> ch_strobe[0] high 2 cycles later for exactly 4 cycles with ch_data[7:0]=A5. Pulse ch_ack[0] -> busy clears.
- With en=0, write 9 bytes to 0x76 -> count read 8. Status 0x77 = 8'h14 (ovf, full). Second read of 0x77 -> 8'h04.
- Write 0x77=8'h04, overflow ch1 -> irq high 1 cycle after the dropped write; read 0x77 -> irq low.
- Start a byte on ch0 with 3 queued, write 0x75=8'h03 (flush) during STROBE -> strobe low next cycle, count 0, FSM IDLE.
- With ASIC_IO_TIMEOUT_EN, TIMEOUT_CYCLES=16, never ack -> after 16 WAIT_ACK cycles tmo=1 and status bit5 set; the next queued byte strobes.
